// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers with shadowed configuration,
// phase offset, shared sync restart and glitch-free registered outputs.
module clk_div_bank #(
  parameter int          CH         = 4,
  parameter int          W          = 32,
  parameter int unsigned DEF_PERIOD = 1000,
  parameter int unsigned DEF_HIGH   = 500,
  parameter int unsigned DEF_PHASE  = 0,
  localparam int         CW         = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            phase_rst,
  input  logic [CH-1:0]   en,
  input  logic            sync,
  input  logic            cfg_wr,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [W-1:0]    cfg_period,
  input  logic [W-1:0]    cfg_high,
  input  logic [W-1:0]    cfg_phase,
  output logic [CH-1:0]   cfg_pending,
  output logic [CH-1:0]   clk_div,
  output logic [CH-1:0]   tick,
  output logic [CH*W-1:0] cnt
);

  localparam logic [W-1:0]  DP     = W'(DEF_PERIOD);
  localparam logic [W-1:0]  DH     = W'(DEF_HIGH);
  localparam logic [W-1:0]  DPH    = W'(DEF_PHASE);
  localparam logic [CW:0]   CH_LIM = (CW + 1)'(CH);
  localparam logic [W-1:0]  ONE    = W'(1);

  logic ch_ok;
  assign ch_ok = ({1'b0, cfg_ch} < CH_LIM);

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [W-1:0] sh_period_q, sh_high_q, sh_phase_q;
    logic [W-1:0] ac_period_q, ac_high_q, ac_phase_q;
    logic [W-1:0] cnt_q, cnt_d;
    logic         pend_q, pend_d;
    logic         en_q;
    logic         div_q, div_d;
    logic         tick_q, tick_d;
    logic         wr_hit, rise, restart, wrap, apply;
    logic [W-1:0] nx_period, nx_high, nx_phase, eff_phase;

    always_comb begin
      wr_hit  = cfg_wr && ch_ok && (cfg_ch == CW'(k));
      rise    = en[k] && !en_q;
      restart = en[k] && (rise || sync);
      wrap    = en[k] && en_q && (ac_period_q != '0) && (cnt_q == ac_period_q - ONE);
      apply   = wrap || restart || !en[k] || (ac_period_q == '0);

      // Apply always takes the shadow as it stood before this edge, so a
      // coincident write survives in the shadow and stays pending.
      nx_period = apply ? sh_period_q : ac_period_q;
      nx_high   = apply ? sh_high_q   : ac_high_q;
      nx_phase  = apply ? sh_phase_q  : ac_phase_q;
      eff_phase = (nx_phase < nx_period) ? nx_phase : '0;

      pend_d = pend_q;
      if (apply)  pend_d = 1'b0;
      if (wr_hit) pend_d = 1'b1;

      cnt_d  = '0;
      tick_d = 1'b0;
      if (!en[k] || nx_period == '0) begin
        cnt_d  = '0;
        tick_d = 1'b0;
      end else if (restart) begin
        cnt_d  = eff_phase;
        tick_d = 1'b1;
      end else if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + ONE;
        tick_d = 1'b0;
      end

      div_d = en[k] && (nx_period != '0) && (cnt_d < nx_high);
    end

    always_ff @(posedge clk or posedge phase_rst) begin
      if (phase_rst) begin
        sh_period_q <= DP;
        sh_high_q   <= DH;
        sh_phase_q  <= DPH;
        ac_period_q <= DP;
        ac_high_q   <= DH;
        ac_phase_q  <= DPH;
        cnt_q       <= '0;
        pend_q      <= 1'b0;
        en_q        <= 1'b0;
        div_q       <= 1'b0;
        tick_q      <= 1'b0;
      end else begin
        if (wr_hit) begin
          sh_period_q <= cfg_period;
          sh_high_q   <= cfg_high;
          sh_phase_q  <= cfg_phase;
        end
        ac_period_q <= nx_period;
        ac_high_q   <= nx_high;
        ac_phase_q  <= nx_phase;
        cnt_q       <= cnt_d;
        pend_q      <= pend_d;
        en_q        <= en[k];
        div_q       <= div_d;
        tick_q      <= tick_d;
      end
    end

    assign cnt[k*W +: W] = cnt_q;
    assign cfg_pending[k] = pend_q;
    assign clk_div[k]     = div_q;
    assign tick[k]        = tick_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank (CH=4, W=32, default config).
module tb_clk_div_bank;
  localparam int CH = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            phase_rst;
  logic [CH-1:0]   en;
  logic            sync;
  logic            cfg_wr;
  logic [1:0]      cfg_ch;
  logic [W-1:0]    cfg_period, cfg_high, cfg_phase;
  logic [CH-1:0]   cfg_pending, clk_div, tick;
  logic [CH*W-1:0] cnt;

  int errors = 0;
  int checks = 0;

  clk_div_bank #(.CH(CH), .W(W)) dut (
    .clk(clk), .phase_rst(phase_rst), .en(en), .sync(sync),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .cfg_pending(cfg_pending), .clk_div(clk_div), .tick(tick), .cnt(cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] cnt_of(input int k);
    return cnt[k*W +: W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input int ch, input int p, input int h, input int ph);
    cfg_wr     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = W'(p);
    cfg_high   = W'(h);
    cfg_phase  = W'(ph);
  endtask

  task automatic test_reset();
    phase_rst = 1'b1; en = '0; sync = 1'b0; cfg_wr = 1'b0;
    cfg_ch = '0; cfg_period = '0; cfg_high = '0; cfg_phase = '0;
    #12;
    checks++; if (cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
    checks++; if (clk_div !== '0) begin errors++; $display("FAIL reset_div got=%b exp=0000", clk_div); end
    checks++; if (tick !== '0) begin errors++; $display("FAIL reset_tick got=%b exp=0000", tick); end
    checks++; if (cfg_pending !== '0) begin errors++; $display("FAIL reset_pending got=%b exp=0000", cfg_pending); end
  endtask

  // Default 1000/500 on ch0; stops with ch0 mid-period at cnt 499.
  task automatic test_default();
    int bad0 = 0, bad_other = 0, ticks = 0, highs = 0;
    en = 4'b0001;
    @(negedge clk);
    phase_rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (cnt_of(0) !== W'(i % 1000) || tick[0] !== (i % 1000 == 0) || clk_div[0] !== (i % 1000 < 500))
        bad0++;
      if (cnt[CH*W-1:W] !== '0 || clk_div[3:1] !== 3'b000 || tick[3:1] !== 3'b000) bad_other++;
      if (tick[0]) ticks++;
      if (i < 1000 && clk_div[0]) highs++;
    end
    checks++; if (bad0 !== 0) begin errors++; $display("FAIL default_ch0 bad_cycles=%0d exp=0", bad0); end
    checks++; if (bad_other !== 0) begin errors++; $display("FAIL default_idle_ch bad_cycles=%0d exp=0", bad_other); end
    checks++; if (ticks !== 2) begin errors++; $display("FAIL default_ticks got=%0d exp=2", ticks); end
    checks++; if (highs !== 500) begin errors++; $display("FAIL default_high got=%0d exp=500", highs); end
  endtask

  task automatic test_midperiod_write();
    int bad = 0;
    drive_cfg(0, 10, 3, 0);
    step();
    cfg_wr = 1'b0;
    checks++; if (cfg_pending[0] !== 1'b1 || cnt_of(0) !== 500) begin
      errors++; $display("FAIL midwr_pending got=%b cnt=%0d exp=1 cnt=500", cfg_pending[0], cnt_of(0)); end
    for (int i = 1501; i < 2000; i++) begin
      step();
      if (cfg_pending[0] !== 1'b1 || cnt_of(0) !== W'(i % 1000)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midwr_hold bad_cycles=%0d exp=0", bad); end
    step();
    checks++; if ({cfg_pending[0], tick[0], clk_div[0]} !== 3'b011 || cnt_of(0) !== 0) begin
      errors++; $display("FAIL midwr_apply got pend/tick/div=%b%b%b cnt=%0d exp=011 cnt=0",
                         cfg_pending[0], tick[0], clk_div[0], cnt_of(0)); end
    bad = 0;
    for (int j = 1; j < 30; j++) begin
      step();
      if (cnt_of(0) !== W'(j % 10) || clk_div[0] !== (j % 10 < 3) || tick[0] !== (j % 10 == 0) || cfg_pending[0] !== 1'b0)
        bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midwr_10_3 bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_phase_sync();
    int bad = 0;
    drive_cfg(0, 8, 4, 0);
    step();
    drive_cfg(1, 8, 4, 2);
    step();
    cfg_wr = 1'b0;
    step();
    en = 4'b0011; sync = 1'b1;
    step();
    sync = 1'b0;
    checks++; if (cnt_of(0) !== 0 || cnt_of(1) !== 2 || tick[1:0] !== 2'b11 || cfg_pending[1:0] !== 2'b00) begin
      errors++; $display("FAIL sync_start got cnt0=%0d cnt1=%0d tick=%b pend=%b exp 0 2 11 00",
                         cnt_of(0), cnt_of(1), tick[1:0], cfg_pending[1:0]); end
    for (int j = 1; j <= 20; j++) begin
      step();
      if (cnt_of(0) !== W'(j % 8) || cnt_of(1) !== W'((j + 2) % 8) ||
          tick[0] !== (j % 8 == 0) || tick[1] !== ((j + 2) % 8 == 0) ||
          clk_div[0] !== (j % 8 < 4) || clk_div[1] !== ((j + 2) % 8 < 4))
        bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL sync_lead bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_high_extremes();
    int bad = 0;
    drive_cfg(0, 10, 0, 0);
    step();
    cfg_wr = 1'b0; sync = 1'b1;
    step();
    sync = 1'b0;
    checks++; if (cnt_of(0) !== 0 || tick[0] !== 1'b1 || clk_div[0] !== 1'b0) begin
      errors++; $display("FAIL high0_start got cnt=%0d tick=%b div=%b exp 0 1 0", cnt_of(0), tick[0], clk_div[0]); end
    for (int j = 1; j < 60; j++) begin
      step();
      if (cnt_of(0) !== W'(j % 10) || tick[0] !== (j % 10 == 0) || clk_div[0] !== (j >= 30) ||
          cfg_pending[0] !== (j >= 26 && j <= 29))
        bad++;
      if (j == 25) drive_cfg(0, 10, 20, 0);
      else cfg_wr = 1'b0;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL high_extremes bad_cycles=%0d exp=0", bad); end
  endtask

  // Entered with ch0 at cnt 9 of a period-10 cycle: the write lands on the wrap edge.
  task automatic test_wr_at_wrap();
    int bad = 0;
    drive_cfg(0, 6, 2, 0);
    for (int t = 0; t <= 30; t++) begin
      step();
      cfg_wr = 1'b0;
      if (t == 0) begin
        checks++; if (cfg_pending[0] !== 1'b1 || tick[0] !== 1'b1 || cnt_of(0) !== 0) begin
          errors++; $display("FAIL wrap_wr_edge got pend=%b tick=%b cnt=%0d exp 1 1 0", cfg_pending[0], tick[0], cnt_of(0)); end
      end
      if (t < 10) begin
        if (cnt_of(0) !== W'(t) || tick[0] !== (t == 0) || clk_div[0] !== 1'b1 || cfg_pending[0] !== 1'b1) bad++;
      end else begin
        if (cnt_of(0) !== W'((t - 10) % 6) || tick[0] !== ((t - 10) % 6 == 0) ||
            clk_div[0] !== ((t - 10) % 6 < 2) || cfg_pending[0] !== 1'b0) bad++;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_wr_follow bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_period_edges();
    int bad = 0;
    drive_cfg(3, 1, 1, 0);
    step();
    cfg_wr = 1'b0;
    step();
    checks++; if (cfg_pending[3] !== 1'b0) begin errors++; $display("FAIL p1_idle_apply got=%b exp=0", cfg_pending[3]); end
    en = 4'b1011;
    for (int t = 0; t < 6; t++) begin
      step();
      if (cnt_of(3) !== 0 || tick[3] !== 1'b1 || clk_div[3] !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL period1 bad_cycles=%0d exp=0", bad); end
    drive_cfg(3, 0, 5, 0);
    step();
    cfg_wr = 1'b0;
    checks++; if (tick[3] !== 1'b1 || cfg_pending[3] !== 1'b1) begin
      errors++; $display("FAIL p0_wr_on_wrap got tick=%b pend=%b exp 1 1", tick[3], cfg_pending[3]); end
    bad = 0;
    for (int t = 0; t < 5; t++) begin
      step();
      if (cnt_of(3) !== 0 || tick[3] !== 1'b0 || clk_div[3] !== 1'b0 || cfg_pending[3] !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL period0 bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    bit found = 1'b0;
    for (int t = 0; t < 12 && !found; t++) begin
      step();
      if (cnt_of(0) == 0) found = 1'b1;
    end
    checks++; if (!found || clk_div[0] !== 1'b1) begin
      errors++; $display("FAIL rst_mid_high got found=%0d div=%b exp 1 1", found, clk_div[0]); end
    drive_cfg(0, 77, 7, 3);
    #2;
    phase_rst = 1'b1;
    #1;
    checks++; if (cnt !== '0 || clk_div !== '0 || tick !== '0 || cfg_pending !== '0) begin
      errors++; $display("FAIL rst_async got cnt=%h div=%b tick=%b pend=%b exp all 0", cnt, clk_div, tick, cfg_pending); end
    step();
    cfg_wr = 1'b0;
    en = 4'b0001;
    @(negedge clk);
    phase_rst = 1'b0;
    for (int i = 0; i <= 600; i++) begin
      step();
      if (cnt_of(0) !== W'(i) || clk_div[0] !== (i < 500) || tick[0] !== (i == 0) || cfg_pending !== '0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_default_cfg bad_cycles=%0d exp=0", bad); end
    checks++; if (cnt_of(0) !== 600) begin errors++; $display("FAIL rst_cnt_600 got=%0d exp=600", cnt_of(0)); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_midperiod_write();
    test_phase_sync();
    test_high_extremes();
    test_wr_at_wrap();
    test_period_edges();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
